// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one 1-bit full-adder cell stepped over WIDTH
// cycles, LSB first, behind a start/busy/done handshake.

// Single-bit full adder cell shared across all bit positions.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// state | meaning
// IDLE  | waiting for start; result outputs hold the last completed add
// RUN   | one operand bit pair per cycle through the cell, LSB first
// DONE  | one-cycle done pulse; a start here begins the next add at once
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             cell_s;
  logic             cell_co;
  logic             load;
  logic [WIDTH-1:0] res_next;

  full_adder_cell u_cell (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (carry),
    .s  (cell_s),
    .co (cell_co)
  );

  // DONE also accepts start so a held start yields one add every WIDTH+1 cycles.
  assign load     = start && ((state == IDLE) || (state == DONE));
  assign res_next = {cell_s, res[WIDTH-1:1]};

  // Sequencer: operand shifting, carry chain, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      res      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (load) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          res   <= res_next;
          carry <= cell_co;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            // carry here is the carry into the MSB position
            sum      <= res_next;
            cout     <= cell_co;
            overflow <= carry ^ cell_co;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8 using an
// expected-result queue filled at start and drained on done.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_cmp;
  int n_mis;
  logic [W+1:0] exp_q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected entry: {cout, overflow, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] s;
    logic       v;
    s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {s[W], v, s[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done (bounded), checks latency from the accepting edge and the popped result.
  task automatic wait_result(input string tag, input int edges_so_far);
    int n;
    logic [W+1:0] e;
    n = edges_so_far;
    while (n < 20) begin
      tick();
      n++;
      if (done) break;
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    end
    check({tag, "_latency"}, n, W);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sum"}, {24'd0, sum}, {24'd0, e[W-1:0]});
      check({tag, "_cout"}, {31'd0, cout}, {31'd0, e[W+1]});
      check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, e[W]});
    end
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    tick();
    check({tag, "_done_width"}, {31'd0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_add(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input bit disturb);
    a = x;
    b = y;
    cin = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(model(x, y, c));
    check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    if (disturb) begin
      tick();
      a = ~x;
      b = x ^ y;
      cin = ~c;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_result(tag, 2);
    end else begin
      wait_result(tag, 0);
    end
  endtask

  initial begin
    int n;
    int ndone;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;

    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    tick();

    do_add("t1_zero", 8'h00, 8'h00, 1'b0, 1'b0);
    do_add("t2_wrap", 8'hFF, 8'h01, 1'b0, 1'b0);
    do_add("t3_sovf", 8'h7F, 8'h01, 1'b0, 1'b0);
    do_add("t4_cin", 8'hA5, 8'h5A, 1'b1, 1'b1);
    do_add("t4b_negovf", 8'h80, 8'hFF, 1'b0, 1'b0);

    // held start: 0x10+0x20 then 0x33+0x44 accepted at edge k+9, then 0x01+0x01 is never taken
    a = 8'h10;
    b = 8'h20;
    cin = 1'b0;
    start = 1'b1;
    tick();
    exp_q.push_back(model(8'h10, 8'h20, 1'b0));
    a = 8'h33;
    b = 8'h44;
    n = 0;
    ndone = 0;
    while (n < 20) begin
      tick();
      n++;
      if (done) break;
    end
    check("t5_first_latency", n, W);
    check("t5_first_sum", {24'd0, sum}, {24'd0, exp_q[0][W-1:0]});
    void'(exp_q.pop_front());
    exp_q.push_back(model(8'h33, 8'h44, 1'b0));
    tick();
    check("t5_rearm_busy", {31'd0, busy}, 32'd1);
    check("t5_rearm_done", {31'd0, done}, 32'd0);
    a = 8'h01;
    b = 8'h01;
    n = 1;
    while (n < 20) begin
      tick();
      n++;
      if (done) break;
    end
    check("t5_period", n, W + 1);
    start = 1'b0;
    check("t5_second_sum", {24'd0, sum}, {24'd0, exp_q[0][W-1:0]});
    check("t5_second_cout", {31'd0, cout}, {31'd0, exp_q[0][W+1]});
    void'(exp_q.pop_front());
    tick();
    check("t5_stop_busy", {31'd0, busy}, 32'd0);

    // reset during the third RUN cycle aborts without a done
    do_add("t6_pre", 8'h11, 8'h22, 1'b0, 1'b0);
    a = 8'h55;
    b = 8'h66;
    cin = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_done", {31'd0, done}, 32'd0);
    check("t6_rst_sum", {24'd0, sum}, 32'd0);
    check("t6_rst_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    check("t6_no_done", ndone, 0);
    do_add("t6_after", 8'h12, 8'h34, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(255));
      rb = W'($urandom_range(255));
      rc = 1'($urandom_range(1));
      do_add("rand", ra, rb, rc, (i % 7) == 0);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
